// File: rtl/divisor_restaurador.sv
// Sequential signed restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// Optional `DIV_SATURATION_EN clamps an overflowing quotient instead of wrapping it.
module divisor_restaurador (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [15:0] dividendo_i,
    input  logic [7:0]  divisor_i,
    output logic [7:0]  cociente_o,
    output logic [7:0]  residuo_o,
    output logic        done_o,
    output logic        ocupado_o,
    output logic        div_cero_o,
    output logic        desborde_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;        // dividend magnitude, becomes the quotient magnitude
    logic [7:0]  dvs_q, dvs_d;
    logic [7:0]  rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sgn_dvd_q, sgn_dvd_d;
    logic        sgn_dvs_q, sgn_dvs_d;
    logic        zero_q, zero_d;

    logic [7:0]  coc_q, coc_d;
    logic [7:0]  res_q, res_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    logic [15:0] abs_dvd;
    logic [7:0]  abs_dvs;
    logic [8:0]  rem_sh;
    logic        trial_ge;
    logic [7:0]  trial;
    logic        q_neg;
    logic        q_ovf;
    logic [7:0]  q_wrap;
    logic [7:0]  q_out;
    logic [7:0]  r_out;

    assign abs_dvd = dividendo_i[15] ? (~dividendo_i + 16'd1) : dividendo_i;
    assign abs_dvs = divisor_i[7] ? (~divisor_i + 8'd1) : divisor_i;

    // Remainder stays below |divisor| <= 128, so 8 bits of state suffice; the shifted value needs 9.
    assign rem_sh   = {rem_q, dvd_q[15]};
    assign trial_ge = rem_sh >= {1'b0, dvs_q};
    assign trial    = rem_sh[7:0] - dvs_q;

    assign q_neg  = sgn_dvd_q ^ sgn_dvs_q;
    assign q_ovf  = q_neg ? (dvd_q > 16'd128) : (dvd_q > 16'd127);
    assign q_wrap = q_neg ? (~dvd_q[7:0] + 8'd1) : dvd_q[7:0];
    assign r_out  = sgn_dvd_q ? (~rem_q + 8'd1) : rem_q;

`ifdef DIV_SATURATION_EN
    assign q_out = q_ovf ? (q_neg ? 8'h80 : 8'h7F) : q_wrap;
`else
    assign q_out = q_wrap;
`endif

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        sgn_dvd_d = sgn_dvd_q;
        sgn_dvs_d = sgn_dvs_q;
        zero_d    = zero_q;
        coc_d     = coc_q;
        res_d     = res_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    dvd_d     = abs_dvd;
                    dvs_d     = abs_dvs;
                    sgn_dvd_d = dividendo_i[15];
                    sgn_dvs_d = divisor_i[7];
                    zero_d    = (divisor_i == 8'd0);
                    rem_d     = 8'd0;
                    cnt_d     = 4'd15;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                rem_d = trial_ge ? trial : rem_sh[7:0];
                dvd_d = {dvd_q[14:0], trial_ge};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (zero_q) begin
                    coc_d = 8'd0;
                    res_d = 8'd0;
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    coc_d = q_out;
                    res_d = r_out;
                    dz_d  = 1'b0;
                    ovf_d = q_ovf;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            dvd_q     <= 16'd0;
            dvs_q     <= 8'd0;
            rem_q     <= 8'd0;
            cnt_q     <= 4'd0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            zero_q    <= 1'b0;
            coc_q     <= 8'd0;
            res_q     <= 8'd0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            sgn_dvd_q <= sgn_dvd_d;
            sgn_dvs_q <= sgn_dvs_d;
            zero_q    <= zero_d;
            coc_q     <= coc_d;
            res_q     <= res_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cociente_o = coc_q;
    assign residuo_o  = res_q;
    assign done_o     = done_q;
    assign ocupado_o  = (state_q != StIdle);
    assign div_cero_o = dz_q;
    assign desborde_o = ovf_q;

endmodule
